// File: rtl/stripe_tx_scheduler_pkg.sv
// Shared types and constants for the striper transmit scheduler.
package stripe_tx_scheduler_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        SKP  = 2'd2
    } stripe_sched_state_e;

    // Symbol times between SKP ordered sets on a running link.
    localparam int STRIPE_SKP_INTERVAL_DEFAULT = 1180;

    // Requester index reached by stepping offs places past ptr, wrapping at n.
    function automatic int rr_index(input int ptr, input int offs, input int n);
        return (ptr + offs) % n;
    endfunction

endpackage

// File: rtl/stripe_tx_scheduler_if.sv
// Requester and striper-facing signals of the transmit scheduler.
// master: the scheduler itself; slave: requesters plus striper.
interface stripe_tx_scheduler_if #(
    parameter int num_lanes = 4,
    parameter int num_req   = 2
);
    localparam int dw    = num_lanes * 8;
    localparam int gid_w = $clog2(num_req);

    logic [num_req-1:0]    req_valid;
    logic [num_req*dw-1:0] req_data;
    logic [num_req-1:0]    req_last;
    logic [num_req-1:0]    req_ready;
    logic                  out_valid;
    logic [dw-1:0]         out_data;
    logic                  out_last;
    logic                  out_ready;
    logic                  out_skp;
    logic                  out_skp_ack;
    logic [gid_w-1:0]      grant_id;
    logic                  busy;

    modport master (
        input  req_valid, req_data, req_last, out_ready, out_skp_ack,
        output req_ready, out_valid, out_data, out_last, out_skp, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, out_ready, out_skp_ack,
        input  req_ready, out_valid, out_data, out_last, out_skp, grant_id, busy
    );
endinterface

// File: rtl/stripe_rr_arb.sv
// Combinational round-robin pick: first valid requester after rr_ptr_i.
module stripe_rr_arb
    import stripe_tx_scheduler_pkg::*;
#(
    parameter  int num_req = 2,
    localparam int gid_w   = $clog2(num_req)
) (
    input  logic [num_req-1:0] req_valid_i,
    input  logic [gid_w-1:0]   rr_ptr_i,
    output logic [gid_w-1:0]   winner_o,
    output logic               any_valid_o
);

    logic found;

    // Scan from the requester after the last owner, wrapping round once.
    always_comb begin
        found    = 1'b0;
        winner_o = '0;
        for (int k = 1; k <= num_req; k++) begin
            if (!found && req_valid_i[rr_index(int'(rr_ptr_i), k, num_req)]) begin
                found    = 1'b1;
                winner_o = gid_w'(rr_index(int'(rr_ptr_i), k, num_req));
            end
        end
        any_valid_o = found;
    end

endmodule

// File: rtl/stripe_tx_scheduler.sv
// Packet-atomic round-robin scheduler in front of byte_striper, with the
// SKP interval timer. SKP requests are only raised between packets.
//
// state | meaning
// IDLE  | between packets; SKP owed goes first, else grant a requester
// XFER  | words of grant_id's packet pass straight through to the striper
// SKP   | out_skp held until the striper acknowledges the ordered set
module stripe_tx_scheduler
    import stripe_tx_scheduler_pkg::*;
#(
    parameter int num_lanes    = 4,
    parameter int num_req      = 2,
    parameter int skp_interval = STRIPE_SKP_INTERVAL_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    stripe_tx_scheduler_if.master sched
);

    localparam int dw    = num_lanes * 8;
    localparam int gid_w = $clog2(num_req);
    localparam int tmr_w = $clog2(skp_interval);
    localparam logic [tmr_w-1:0] tmr_last = tmr_w'(skp_interval - 1);

    stripe_sched_state_e state_q, state_d;
    logic [gid_w-1:0]    rr_ptr_q, rr_ptr_d;
    logic [gid_w-1:0]    grant_q, grant_d;
    logic [tmr_w-1:0]    timer_q, timer_d;
    logic                skp_pend_q, skp_pend_d;
    logic                tmr_expire;

    logic [gid_w-1:0]    arb_winner;
    logic                arb_any;

    logic                out_valid_c;
    logic                out_last_c;
    logic [dw-1:0]       out_data_c;
    logic [num_req-1:0]  req_ready_c;
    logic                out_skp_c;

    stripe_rr_arb #(.num_req(num_req)) u_arb (
        .req_valid_i (sched.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (arb_winner),
        .any_valid_o (arb_any)
    );

    // Free-running SKP timer; a second expiry while one SKP is owed is absorbed.
    always_comb begin
        tmr_expire = (timer_q == tmr_last);
        timer_d    = tmr_expire ? '0 : timer_q + tmr_w'(1);
        skp_pend_d = skp_pend_q;
        if (state_q == SKP && sched.out_skp_ack) begin
            skp_pend_d = 1'b0;
        end else if (tmr_expire) begin
            skp_pend_d = 1'b1;
        end
    end

    // Next state, grant/pointer updates and the output mux.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        out_data_c  = '0;
        req_ready_c = '0;
        out_skp_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (skp_pend_q) begin
                    state_d = SKP;
                end else if (arb_any) begin
                    grant_d = arb_winner;
                    state_d = XFER;
                end
            end
            XFER: begin
                out_valid_c          = sched.req_valid[grant_q];
                out_last_c           = sched.req_last[grant_q];
                out_data_c           = sched.req_data[int'(grant_q)*dw +: dw];
                req_ready_c[grant_q] = sched.out_ready;
                if (out_valid_c && sched.out_ready && out_last_c) begin
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end
            end
            SKP: begin
                out_skp_c = 1'b1;
                if (sched.out_skp_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; rr_ptr starts at the last requester so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= gid_w'(num_req - 1);
            grant_q    <= '0;
            timer_q    <= '0;
            skp_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            timer_q    <= timer_d;
            skp_pend_q <= skp_pend_d;
        end
    end

    assign sched.out_valid = out_valid_c;
    assign sched.out_last  = out_last_c;
    assign sched.out_data  = out_data_c;
    assign sched.req_ready = req_ready_c;
    assign sched.out_skp   = out_skp_c;
    assign sched.grant_id  = grant_q;
    assign sched.busy      = (state_q != IDLE);

endmodule

// File: doc/stripe_tx_scheduler.md
# stripe_tx_scheduler

Transmit-side scheduler in front of `byte_striper`. It shares the striper's single input between `num_req` packet sources, such as TLP and DLLP transmitters, using packet-atomic round-robin arbitration. It also runs the SKP ordered-set interval timer and inserts SKP requests only at packet boundaries. Its output drives the striper's input-side signals (`i_striper_ifc`) directly.

## Interface

Parameters:
- `num_lanes`, default 4: lane count; the data word is `num_lanes*8` bits (one symbol per lane per cycle).
- `num_req`, default 2: number of requesters, minimum 2.
- `skp_interval`, default 1180: symbol times (cycles) between SKP requests, minimum 4.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  num_req  requester i has a word.
- `req_data`  in  num_req*num_lanes*8  word of requester i, in slice i.
- `req_last`  in  num_req  word is the last of requester i's packet.
- `req_ready`  out  num_req  word of requester i accepted.
- `out_valid`  out  1  word to striper.
- `out_data`  out  num_lanes*8  word to striper.
- `out_last`  out  1  end of packet.
- `out_ready`  in  1  striper accepts the word.
- `out_skp`  out  1  request SKP ordered-set insertion.
- `out_skp_ack`  in  1  striper has issued the SKP.
- `grant_id`  out  $clog2(num_req)  current owner, valid in XFER.
- `busy`  out  1  state is not IDLE.

## Operation

- FSM states: IDLE, XFER, SKP.
- IDLE:
  - If `skp_pending` is set, go to SKP.
  - Otherwise, if any `req_valid` is high, grant the first valid requester searching from `rr_ptr+1` with wrap-around, register it in `grant_id`, and go to XFER.
  - Otherwise stay in IDLE.
- XFER:
  - `out_valid`, `out_data` and `out_last` are combinational muxes of requester `grant_id`.
  - `req_ready[grant_id] = out_ready`; all other `req_ready` bits are 0.
  - On `out_valid && out_ready && out_last`: set `rr_ptr <= grant_id` and go to IDLE.
  - The grant is never revoked mid-packet. `req_valid` low mid-packet only stalls the transfer.
- SKP: `out_skp` is 1 and `out_valid` is 0. On `out_skp_ack`, clear `skp_pending` and go to IDLE.
- SKP timer (`$clog2(skp_interval)` bits):
  - Increments every cycle in every state.
  - When it reaches `skp_interval-1`, it wraps to 0 and sets `skp_pending`.
  - A further expiry while `skp_pending` is already set is absorbed; only one SKP is owed.
- Priority: SKP before any grant. A requester can wait at most one packet from each other requester plus one SKP.
- Outside XFER: `out_valid`, `out_last` and all `req_ready` bits are 0.

## Timing

- Reset values:
  - `state` = IDLE
  - `rr_ptr` = num_req-1, so requester 0 wins first
  - timer = 0, `skp_pending` = 0
  - `grant_id` = 0, `out_skp` = 0, `busy` = 0
  - `out_valid` = 0, `out_last` = 0, `req_ready` = 0
- Arbitration latency: `req_valid` high in IDLE at cycle N gives `out_valid` at N+1.
- Back-to-back packets: exactly one IDLE bubble cycle after each accepted last word.
- Single-word packet (`req_last` on the first word): occupies one XFER cycle when `out_ready` is high.
- Timer expiry:
  - At cycle N, `skp_pending` is visible at N+1.
  - Expiry in the same cycle as an IDLE grant: the grant proceeds, and SKP follows that packet.
  - Expiry during XFER: SKP is entered directly after the packet's IDLE cycle.
- `out_skp_ack` is only sampled in SKP.
- `rst` mid-packet or mid-SKP: all state returns to its reset value on the next edge. The partially sent packet is abandoned; the striper is reset by the same `rst`.

## Structure

- `striper_pkg` additions:
  - `stripe_sched_state_e` (IDLE/XFER/SKP).
  - `STRIPE_SKP_INTERVAL_DEFAULT = 1180`.
- Sub-module `stripe_rr_arb`: combinational round-robin pick from `req_valid` and `rr_ptr`, giving a `winner` index and `any_valid`. The pointer register stays in the parent.

## Test plan

- Reset, then requester 0 sends a 3-word packet with `out_ready` held at 1:
  - `out_valid` at cycles 1..3 after the request, `grant_id` = 0, `out_last` on the third word, then IDLE.
- Both requesters continuously valid with 2-word packets:
  - Grants alternate 0,1,0,1, with one bubble between packets.
- Requester 1 granted mid-packet, `out_ready` toggling and `req_valid[1]` dropping for 2 cycles:
  - No data lost or duplicated.
  - `grant_id` stays 1 until the last word.
  - `req_ready[0]` stays 0.
- `skp_interval` = 8 with an idle bus:
  - `out_skp` rises at cycle 9 after reset.
  - Holding off `out_skp_ack` for 20 cycles gives exactly one SKP, then `out_skp` returns to 0.
- Timer expiring during a 10-word packet:
  - The packet completes intact.
  - SKP occurs before the next grant, even with requester 0 valid.
- `rst` asserted in the 2nd word of an XFER:
  - Next cycle, all outputs equal their reset values.
  - The first grant afterwards goes to requester 0.
